// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between NUM_REQ requesters.
// Requesters hand over {srca, srcb, op} with valid/ready. One is granted,
// its operands are registered onto the alu_* outputs, and the ALU result
// comes back as a response tagged with the requester index.
// Ports: clk, reset (sync, active-high); req_valid/req_ready/req_srca/
// req_srcb/req_op (packed per requester); alu_srca/alu_srcb/alu_op (to ALU);
// alu_result (from ALU); rsp_valid/rsp_ready/rsp_data/rsp_id (response).
// Build option: define ALU_ARB_RR_EN for round-robin arbitration; without
// it the lowest asserted requester index wins (fixed priority).
module alu_share_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int NUM_REQ       = 2,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb,
    input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
    output logic [DATA_WIDTH-1:0]            alu_srca,
    output logic [DATA_WIDTH-1:0]            alu_srcb,
    output logic [OPCODE_LENGTH-1:0]         alu_op,
    input  logic [DATA_WIDTH-1:0]            alu_result,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic [ID_W-1:0]                  rsp_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nx;

    logic                     any;
    logic [ID_W-1:0]          gnt;
    logic [DATA_WIDTH-1:0]    sel_a;
    logic [DATA_WIDTH-1:0]    sel_b;
    logic [OPCODE_LENGTH-1:0] sel_op;
    logic                     accept;
    logic                     capture;

`ifdef ALU_ARB_RR_EN
    logic [ID_W-1:0] rr_ptr;

    // Search starts at rr_ptr and wraps; idx is one bit wider so the
    // wrap can be done with a single conditional subtract.
    always_comb begin
        logic [ID_W:0] idx;
        idx = '0;
        any = 1'b0;
        gnt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ))
                idx = idx - (ID_W+1)'(NUM_REQ);
            if (!any && req_valid[idx[ID_W-1:0]]) begin
                any = 1'b1;
                gnt = idx[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= '0;
        else if (accept)
            rr_ptr <= (gnt == ID_W'(NUM_REQ-1)) ? '0 : gnt + ID_W'(1);
    end
`else
    // Descending scan so the lowest asserted index is the last writer.
    always_comb begin
        any = 1'b0;
        gnt = '0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any = 1'b1;
                gnt = ID_W'(i);
            end
        end
    end
`endif

    // Operand mux with constant slices only.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (gnt == ID_W'(j)) begin
                sel_a  = req_srca[j*DATA_WIDTH +: DATA_WIDTH];
                sel_b  = req_srcb[j*DATA_WIDTH +: DATA_WIDTH];
                sel_op = req_op[j*OPCODE_LENGTH +: OPCODE_LENGTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        capture   = 1'b0;
        req_ready = '0;
        unique case (state)
            IDLE: begin
                if (any) begin
                    accept         = 1'b1;
                    req_ready[gnt] = 1'b1;
                    state_nx       = EXEC;
                end
            end
            EXEC: begin
                capture  = 1'b1;
                state_nx = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Response valid is exactly "in RESP", a registered state decode.
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_srca <= '0;
            alu_srcb <= '0;
            alu_op   <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            if (accept) begin
                alu_srca <= sel_a;
                alu_srcb <= sel_b;
                alu_op   <= sel_op;
                rsp_id   <= gnt;
            end
            if (capture)
                rsp_data <= alu_result;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: table vectors, corner sequences and
// randomized traffic against a behavioural ALU and arbitration model.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_srca;
    logic [63:0] req_srcb;
    logic [7:0]  req_op;
    logic [31:0] alu_srca;
    logic [31:0] alu_srcb;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_id;

    int errors = 0;
    int checks = 0;
    int rr_m   = 0;

    alu_share_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_srca   (req_srca),
        .req_srcb   (req_srcb),
        .req_op     (req_op),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a - b;
            4'b1000: return (a == b) ? 32'd1 : 32'd0;
            4'b1001: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // Stand-in for the shared ALU.
    always_comb alu_result = alu_ref(alu_op, alu_srca, alu_srcb);

    function automatic int pick(input logic [1:0] m);
`ifdef ALU_ARB_RR_EN
        for (int k = 0; k < 2; k++) begin
            int i;
            i = (rr_m + k) % 2;
            if (m[i]) return i;
        end
`else
        for (int i = 0; i < 2; i++)
            if (m[i]) return i;
`endif
        return -1;
    endfunction

    task automatic granted(input int g);
`ifdef ALU_ARB_RR_EN
        rr_m = (g + 1) % 2;
`else
        rr_m = g;
`endif
    endtask

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction from IDLE back to IDLE with rsp_ready held high.
    // Operand buses must already be driven by the caller.
    task automatic txn(input logic [1:0] mask, input int g,
                       input logic [31:0] exp_d, input string nm);
        logic [31:0] ea, eb;
        logic [3:0]  eo;
        ea = req_srca[g*32 +: 32];
        eb = req_srcb[g*32 +: 32];
        eo = req_op[g*4 +: 4];
        req_valid = mask;
        rsp_ready = 1'b1;
        #1;
        check({nm, " ready"}, 64'(req_ready), 64'(2'b01 << g));
        tick();
        req_valid = 2'b00;
        check({nm, " exec ready"}, 64'(req_ready), 64'd0);
        check({nm, " exec valid"}, 64'(rsp_valid), 64'd0);
        check({nm, " alu_srca"}, 64'(alu_srca), 64'(ea));
        check({nm, " alu_srcb"}, 64'(alu_srcb), 64'(eb));
        check({nm, " alu_op"}, 64'(alu_op), 64'(eo));
        tick();
        check({nm, " rsp_valid"}, 64'(rsp_valid), 64'd1);
        check({nm, " rsp_data"}, 64'(rsp_data), 64'(exp_d));
        check({nm, " rsp_id"}, 64'(rsp_id), 64'(g));
        tick();
        check({nm, " back idle"}, 64'(rsp_valid), 64'd0);
        granted(g);
    endtask

    typedef struct {
        int          req;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{0, 32'd5,      32'd3,      4'b0010, 32'd8};
        vecs[1] = '{1, 32'h10,     32'h11,     4'b0011, 32'hFFFF_FFFF};
        vecs[2] = '{1, 32'h80,     32'd4,      4'b1001, 32'h8};
        vecs[3] = '{1, 32'd7,      32'd7,      4'b1000, 32'd1};
        vecs[4] = '{0, 32'd9,      32'd9,      4'b0111, 32'd0};
        vecs[5] = '{0, 32'hF0F0,   32'h0FF0,   4'b0000, 32'h00F0};
        vecs[6] = '{1, 32'hF000,   32'h000F,   4'b0001, 32'hF00F};
        vecs[7] = '{0, 32'd7,      32'd8,      4'b1000, 32'd0};

        reset     = 1'b1;
        req_valid = 2'b00;
        req_srca  = '0;
        req_srcb  = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset req_ready", 64'(req_ready), 64'd0);
        check("reset alu_srca", 64'(alu_srca), 64'd0);
        check("reset alu_srcb", 64'(alu_srcb), 64'd0);
        check("reset alu_op", 64'(alu_op), 64'd0);
        check("reset rsp_data", 64'(rsp_data), 64'd0);
        check("reset rsp_id", 64'(rsp_id), 64'd0);
        rr_m = 0;

        // Idle with no requests: nothing is accepted.
        tick();
        tick();
        check("idle no ready", 64'(req_ready), 64'd0);
        check("idle no rsp", 64'(rsp_valid), 64'd0);

        for (int v = 0; v < 8; v++) begin
            req_srca = {$urandom, $urandom};
            req_srcb = {$urandom, $urandom};
            req_op   = 8'($urandom);
            req_srca[vecs[v].req*32 +: 32] = vecs[v].a;
            req_srcb[vecs[v].req*32 +: 32] = vecs[v].b;
            req_op[vecs[v].req*4 +: 4]     = vecs[v].op;
            txn(2'b01 << vecs[v].req, vecs[v].req, vecs[v].exp,
                $sformatf("vec%0d", v));
        end

        // Contention from a fresh reset: both requesters always valid.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rr_m  = 0;
        req_srca = {32'd20, 32'd10};
        req_srcb = {32'd2,  32'd1};
        req_op   = {4'b0010, 4'b0010};
        for (int n = 0; n < 4; n++) begin
            int eg;
`ifdef ALU_ARB_RR_EN
            eg = n % 2;
`else
            eg = 0;
`endif
            txn(2'b11, eg, (eg == 0) ? 32'd11 : 32'd22,
                $sformatf("contend%0d", n));
        end

        // Backpressure: response held for 5 cycles, then released.
        begin
            int g1, g2;
            logic [31:0] d1;
            req_srca = {32'd100, 32'd50};
            req_srcb = {32'd3,   32'd4};
            req_op   = {4'b0011, 4'b0010};
            g1 = pick(2'b11);
            d1 = (g1 == 0) ? 32'd54 : 32'd97;
            req_valid = 2'b11;
            rsp_ready = 1'b0;
            #1;
            check("bp ready", 64'(req_ready), 64'(2'b01 << g1));
            tick();
            granted(g1);
            tick();
            for (int c = 0; c < 5; c++) begin
                check($sformatf("bp%0d valid", c), 64'(rsp_valid), 64'd1);
                check($sformatf("bp%0d data", c), 64'(rsp_data), 64'(d1));
                check($sformatf("bp%0d id", c), 64'(rsp_id), 64'(g1));
                check($sformatf("bp%0d ready", c), 64'(req_ready), 64'd0);
                tick();
            end
            rsp_ready = 1'b1;
            tick();
            g2 = pick(2'b11);
            check("bp release valid", 64'(rsp_valid), 64'd0);
            check("bp next grant", 64'(req_ready), 64'(2'b01 << g2));
            tick();
            req_valid = 2'b00;
            granted(g2);
            tick();
            check("bp2 id", 64'(rsp_id), 64'(g2));
            check("bp2 data", 64'(rsp_data),
                  64'((g2 == 0) ? 32'd54 : 32'd97));
            tick();
        end

        // Reset while in EXEC discards the transaction.
        req_srca = {32'd0, 32'd1};
        req_srcb = {32'd0, 32'd1};
        req_op   = {4'b0000, 4'b0010};
        req_valid = 2'b01;
        #1;
        check("rst-exec accept", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b00;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        rr_m  = 0;
        check("rst-exec rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst-exec req_ready", 64'(req_ready), 64'd0);
        check("rst-exec alu_srca", 64'(alu_srca), 64'd0);
        check("rst-exec alu_srcb", 64'(alu_srcb), 64'd0);
        check("rst-exec alu_op", 64'(alu_op), 64'd0);
        check("rst-exec rsp_data", 64'(rsp_data), 64'd0);
        check("rst-exec rsp_id", 64'(rsp_id), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("rst-exec quiet%0d", c), 64'(rsp_valid), 64'd0);
        end
        req_srca = {32'd6, 32'd5};
        req_srcb = {32'd6, 32'd5};
        req_op   = {4'b0010, 4'b0010};
        txn(2'b11, 0, 32'd10, "post-rst contend");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [3:0] ops [8];
            logic [1:0] m;
            int g;
            ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011,
                    4'b1000, 4'b1001, 4'b0111, 4'b1111};
            req_srca = {$urandom, $urandom};
            req_srcb = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0)
                req_srcb[31:0] = req_srca[31:0];
            req_op = {ops[$urandom_range(0, 7)], ops[$urandom_range(0, 7)]};
            m = 2'($urandom_range(1, 3));
            g = pick(m);
            txn(m, g, alu_ref(req_op[g*4 +: 4], req_srca[g*32 +: 32],
                              req_srcb[g*32 +: 32]),
                $sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
